bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits directly upstream of the BCD-to-decimal one-hot decoders. Each 4-bit digit of `out_bcd` drives one decoder's BCD input, so a binary count or measurement is presented as per-digit decimal lines. Valid/ready handshakes are used on both sides.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_add3.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 83 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Minimum number of decimal digits needed to hold 2^bin_w - 1.
  function automatic int unsigned bcd_digits(input int unsigned bin_w);
    longint unsigned v;
    int unsigned d;
    v = (64'd1 << bin_w) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
import bcd_pkg::*;

module bcd_add3 (
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  assign q = (d >= BCD_DIGIT_W'(5)) ? d + BCD_DIGIT_W'(3) : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock,
// with valid/ready handshakes on input and output.
import bcd_pkg::*;

module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              in_bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          busy
);

  localparam int unsigned ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < bcd_digits(BIN_W)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_sr;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_corr;
  logic [ACC_W-1:0]   acc_next;

  // Per-digit add-3 correction ahead of each shift.
  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    bcd_add3 u_add3 (
      .d (acc[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (acc_corr[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign acc_next = (acc_corr << 1) | ACC_W'(bin_sr[BIN_W-1]);

  assign in_ready  = (state == IDLE) && rst_n;
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);

  // Final iteration writes the finished accumulator straight into out_bcd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bin_sr  <= '0;
      acc     <= '0;
      out_bcd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sr <= in_bin;
            acc    <= '0;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr <= bin_sr << 1;
          acc    <= acc_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            out_bcd <= acc_next;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: an 8-bit/3-digit and a 10-bit/4-digit
// instance, directed vectors, corner sequences and randomized full sweeps.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        in_valid;
  logic        out_ready;
  logic [9:0]  in_bin;

  logic        iv8, iv10, or8, or10;
  logic        ir8, ir10, ov8, ov10, busy8, busy10;
  logic [11:0] ob8;
  logic [15:0] ob10;

  logic        in_ready_s, out_valid_s, busy_s;
  logic [15:0] out_bcd_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign iv8  = in_valid & ~sel;
  assign iv10 = in_valid & sel;
  assign or8  = out_ready & ~sel;
  assign or10 = out_ready & sel;

  assign in_ready_s  = sel ? ir10 : ir8;
  assign out_valid_s = sel ? ov10 : ov8;
  assign busy_s      = sel ? busy10 : busy8;
  assign out_bcd_s   = sel ? ob10 : {4'h0, ob8};

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .in_bin(in_bin[7:0]), .out_valid(ov8), .out_ready(or8),
    .out_bcd(ob8), .busy(busy8)
  );

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10),
    .in_bin(in_bin), .out_valid(ov10), .out_ready(or10),
    .out_bcd(ob10), .busy(busy10)
  );

  typedef struct {
    logic        sel;
    int          v;
    logic [15:0] exp;
  } vec_t;

  // Decimal digits by plain division, independent of the shift-add method.
  function automatic logic [15:0] ref_bcd(input int v, input int nd);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready_s && n < 100) begin
      step();
      n++;
    end
    check({name, " ready"}, 32'(in_ready_s), 32'd1);
  endtask

  // Handshake v, then expect busy for bw cycles followed by out_valid.
  task automatic start_conv(input logic [9:0] v, input int bw, input string name);
    int bc;
    in_bin   = v;
    in_valid = 1'b1;
    wait_ready(name);
    step();
    in_valid = 1'b0;
    bc = 0;
    for (int i = 0; i < bw; i++) begin
      if (busy_s && !out_valid_s) bc++;
      step();
    end
    check({name, " busy_cycles"}, 32'(bc), 32'(bw));
    check({name, " out_valid"}, 32'(out_valid_s), 32'd1);
  endtask

  task automatic finish_conv(input logic [15:0] exp, input string name);
    check({name, " out_bcd"}, 32'(out_bcd_s), 32'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, " idle_ready"}, 32'(in_ready_s), 32'd1);
    check({name, " valid_drop"}, 32'(out_valid_s), 32'd0);
  endtask

  task automatic run_stream(input int nvals, input int nd, input int bw);
    int sent, got, extra;
    sent = 0;
    got  = 0;
    fork
      begin
        int  cyc;
        bit  hs;
        cyc = 0;
        while (sent < nvals && cyc < 60000) begin
          in_bin   = 10'(sent);
          in_valid = ($urandom_range(0, 3) != 0);
          hs = in_valid && in_ready_s;
          step();
          if (hs) sent++;
          cyc++;
        end
        in_valid = 1'b0;
      end
      begin
        int          cyc;
        bit          hs;
        logic [15:0] cap;
        cyc = 0;
        while (got < nvals && cyc < 60000) begin
          out_ready = ($urandom_range(0, 2) != 0);
          cap = out_bcd_s;
          hs  = out_valid_s && out_ready;
          step();
          if (hs) begin
            check($sformatf("stream%0d v=%0d", bw, got), 32'(cap), 32'(ref_bcd(got, nd)));
            got++;
          end
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    check($sformatf("stream%0d count", bw), 32'(got), 32'(nvals));
    out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 3 * bw; i++) begin
      if (out_valid_s) extra++;
      step();
    end
    out_ready = 1'b0;
    check($sformatf("stream%0d extra", bw), 32'(extra), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[11];
    int   cnt;

    vecs[0]  = '{1'b0, 0,    16'h0000};
    vecs[1]  = '{1'b0, 9,    16'h0009};
    vecs[2]  = '{1'b0, 10,   16'h0010};
    vecs[3]  = '{1'b0, 99,   16'h0099};
    vecs[4]  = '{1'b0, 100,  16'h0100};
    vecs[5]  = '{1'b0, 128,  16'h0128};
    vecs[6]  = '{1'b0, 255,  16'h0255};
    vecs[7]  = '{1'b1, 1023, 16'h1023};
    vecs[8]  = '{1'b1, 0,    16'h0000};
    vecs[9]  = '{1'b1, 999,  16'h0999};
    vecs[10] = '{1'b1, 1000, 16'h1000};

    // Reset with in_valid high
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b1; in_bin = 10'd5; out_ready = 1'b0;
    step();
    step();
    check("rst in_ready", 32'(in_ready_s), 32'd0);
    check("rst out_valid", 32'(out_valid_s), 32'd0);
    check("rst out_bcd", 32'(out_bcd_s), 32'h000);
    check("rst busy", 32'(busy_s), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst release in_ready", 32'(in_ready_s), 32'd1);

    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      start_conv(10'(vecs[i].v), vecs[i].sel ? 10 : 8, $sformatf("vec%0d", vecs[i].v));
      finish_conv(vecs[i].exp, $sformatf("vec%0d", vecs[i].v));
    end
    sel = 1'b0;

    // Backpressure with an ignored input request
    start_conv(10'd57, 8, "bp57");
    in_valid = 1'b1;
    in_bin   = 10'd77;
    for (int i = 0; i < 5; i++) begin
      check("bp hold out_bcd", 32'(out_bcd_s), 32'h057);
      check("bp hold in_ready", 32'(in_ready_s), 32'd0);
      check("bp hold out_valid", 32'(out_valid_s), 32'd1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp release in_ready", 32'(in_ready_s), 32'd1);
    check("bp release out_valid", 32'(out_valid_s), 32'd0);
    start_conv(10'd42, 8, "bp42");
    finish_conv(16'h0042, "bp42");

    // out_ready and in_valid together in DONE
    start_conv(10'd13, 8, "sim13");
    check("sim13 out_bcd", 32'(out_bcd_s), 32'h013);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bin    = 10'd10;
    step();
    out_ready = 1'b0;
    check("sim not accepted busy", 32'(busy_s), 32'd0);
    check("sim idle in_ready", 32'(in_ready_s), 32'd1);
    step();
    in_valid = 1'b0;
    check("sim accepted busy", 32'(busy_s), 32'd1);
    for (int i = 0; i < 8; i++) step();
    check("sim10 out_valid", 32'(out_valid_s), 32'd1);
    finish_conv(16'h0010, "sim10");

    // Reset on the 4th SHIFT cycle
    in_bin   = 10'd200;
    in_valid = 1'b1;
    wait_ready("mid200");
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    check("mid busy", 32'(busy_s), 32'd0);
    check("mid out_valid", 32'(out_valid_s), 32'd0);
    check("mid in_ready", 32'(in_ready_s), 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid_s) cnt++;
      step();
    end
    check("mid no valid", 32'(cnt), 32'd0);
    start_conv(10'd37, 8, "mid37");
    finish_conv(16'h0037, "mid37");

    run_stream(256, 3, 8);
    sel = 1'b1;
    run_stream(1024, 4, 10);
    sel = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
